// File: rtl/commit_controller.sv
// In-order commit controller: retires the RoB head, handles store handshakes and redirects on mispredicts.
// Optional COMMIT_PERF_CNT_EN adds commit and mispredict counters.
module commit_controller #(
    parameter int unsigned RoB_WIDTH    = 8,
    parameter int unsigned EX_REG_WIDTH = 6
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,
    input  logic                    RoBCC_head_valid,
    input  logic                    RoBCC_head_ready,
    input  logic [1:0]              RoBCC_head_type,
    input  logic [RoB_WIDTH-1:0]    RoBCC_head_index,
    input  logic [EX_REG_WIDTH-1:0] RoBCC_head_rd,
    input  logic [31:0]             RoBCC_head_value,
    input  logic                    RoBCC_head_pred,
    input  logic                    RoBCC_head_taken,
    input  logic [31:0]             RoBCC_head_target,
    output logic                    CCRoB_pop,
    output logic                    CCRF_en,
    output logic [RoB_WIDTH-1:0]    CCRF_RoB_index,
    output logic [EX_REG_WIDTH-1:0] CCRF_rd,
    output logic [31:0]             CCRF_value,
    output logic                    CCRF_pre_judge,
    output logic                    CCLSB_store_req,
    output logic [RoB_WIDTH-1:0]    CCLSB_store_index,
    input  logic                    LSBCC_store_done,
    output logic                    CCIF_flush,
`ifdef COMMIT_PERF_CNT_EN
    output logic [31:0]             CC_commit_cnt,
    output logic [31:0]             CC_mispred_cnt,
`endif
    output logic [31:0]             CCIF_pc
);

    localparam logic [EX_REG_WIDTH-1:0] NON_REG = EX_REG_WIDTH'(6'b100000);

    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;
    localparam logic [1:0] TYPE_JALR   = 2'd3;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] target, target_nxt;
    logic        go;

    // State and redirect target register
    always_ff @(posedge Sys_clk or posedge Sys_rst) begin
        if (Sys_rst) begin
            state  <= RUN;
            target <= 32'd0;
        end else begin
            state  <= state_nxt;
            target <= target_nxt;
        end
    end

    // Next state and combinational outputs; reset and freeze both mask every enable
    always_comb begin
        state_nxt         = state;
        target_nxt        = target;
        CCRoB_pop         = 1'b0;
        CCRF_en           = 1'b0;
        CCRF_RoB_index    = '0;
        CCRF_rd           = NON_REG;
        CCRF_value        = 32'd0;
        CCRF_pre_judge    = 1'b1;
        CCLSB_store_req   = 1'b0;
        CCLSB_store_index = '0;
        CCIF_flush        = 1'b0;
        CCIF_pc           = 32'd0;

        go = !Sys_rst && Sys_rdy && (state == RUN) && RoBCC_head_valid && RoBCC_head_ready;

        if (!Sys_rst && Sys_rdy) begin
            case (state)
                RUN: begin
                    if (go) begin
                        case (RoBCC_head_type)
                            TYPE_REG, TYPE_JALR: begin
                                CCRoB_pop      = 1'b1;
                                CCRF_en        = 1'b1;
                                CCRF_RoB_index = RoBCC_head_index;
                                CCRF_rd        = RoBCC_head_rd;
                                CCRF_value     = RoBCC_head_value;
                                if (RoBCC_head_type == TYPE_JALR) begin
                                    target_nxt = RoBCC_head_target;
                                    state_nxt  = FLUSH;
                                end
                            end
                            TYPE_STORE: begin
                                CCLSB_store_req   = 1'b1;
                                CCLSB_store_index = RoBCC_head_index;
                                state_nxt         = STORE_WAIT;
                            end
                            TYPE_BRANCH: begin
                                CCRoB_pop = 1'b1;
                                if (RoBCC_head_pred != RoBCC_head_taken) begin
                                    target_nxt = RoBCC_head_target;
                                    state_nxt  = FLUSH;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                STORE_WAIT: begin
                    if (LSBCC_store_done) begin
                        CCRoB_pop = 1'b1;
                        state_nxt = RUN;
                    end
                end
                FLUSH: begin
                    CCRF_pre_judge = 1'b0;
                    CCIF_flush     = 1'b1;
                    CCIF_pc        = target;
                    state_nxt      = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

`ifdef COMMIT_PERF_CNT_EN
    // Retirement and redirect counters, free-running modulo 2^32
    always_ff @(posedge Sys_clk or posedge Sys_rst) begin
        if (Sys_rst) begin
            CC_commit_cnt  <= 32'd0;
            CC_mispred_cnt <= 32'd0;
        end else begin
            if (CCRoB_pop)
                CC_commit_cnt <= CC_commit_cnt + 32'd1;
            if (state_nxt == FLUSH && state != FLUSH)
                CC_mispred_cnt <= CC_mispred_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_commit_controller.sv
// Randomized scoreboard bench for commit_controller; expected outputs come from a behavioural model.
// Build with COMMIT_PERF_CNT_EN defined to also check the performance counters.
module tb_commit_controller;

    localparam int unsigned RW = 8;
    localparam int unsigned XW = 6;
    localparam logic [XW-1:0] NONR = 6'b100000;

    logic          clk = 1'b0, rst = 1'b1, rdy = 1'b1;
    logic          hv = 1'b0, hr = 1'b0, pred = 1'b0, taken = 1'b0, done = 1'b0;
    logic [1:0]    ty = 2'd0;
    logic [RW-1:0] idx = '0;
    logic [XW-1:0] rd = '0;
    logic [31:0]   val = '0, tgt = '0;

    logic          pop, en, pj, sreq, flush;
    logic [RW-1:0] ridx, sidx;
    logic [XW-1:0] rrd;
    logic [31:0]   rval, pc;
`ifdef COMMIT_PERF_CNT_EN
    logic [31:0]   ccnt, mcnt;
`endif

    commit_controller #(.RoB_WIDTH(RW), .EX_REG_WIDTH(XW)) dut (
        .Sys_clk(clk), .Sys_rst(rst), .Sys_rdy(rdy),
        .RoBCC_head_valid(hv), .RoBCC_head_ready(hr), .RoBCC_head_type(ty),
        .RoBCC_head_index(idx), .RoBCC_head_rd(rd), .RoBCC_head_value(val),
        .RoBCC_head_pred(pred), .RoBCC_head_taken(taken), .RoBCC_head_target(tgt),
        .CCRoB_pop(pop), .CCRF_en(en), .CCRF_RoB_index(ridx), .CCRF_rd(rrd),
        .CCRF_value(rval), .CCRF_pre_judge(pj), .CCLSB_store_req(sreq),
        .CCLSB_store_index(sidx), .LSBCC_store_done(done), .CCIF_flush(flush),
`ifdef COMMIT_PERF_CNT_EN
        .CC_commit_cnt(ccnt), .CC_mispred_cnt(mcnt),
`endif
        .CCIF_pc(pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pop, en, pj, sreq, flush;
        logic [31:0] ridx, rd, val, sidx, pc, ccnt, mcnt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_fail = 0, cyc = 0;

    // Behavioural model: 0 = retiring normally, 1 = waiting on a store, 2 = redirecting fetch
    int          m_mode = 0;
    logic [31:0] m_tgt = 0;
    int unsigned m_commits = 0, m_redirects = 0;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    // Issue one cycle: predict outputs for the current inputs, queue them, then advance the model
    task automatic step();
        exp_t e;
        int   nm = m_mode;
        logic [31:0] nt = m_tgt;
        e = '{pop:0, en:0, pj:1, sreq:0, flush:0, ridx:0, rd:32'(NONR), val:0, sidx:0, pc:0,
              ccnt:m_commits, mcnt:m_redirects, cyc:cyc};
        if (rst) begin
            nm = 0; nt = 0;
            e.ccnt = 0; e.mcnt = 0;
        end else if (rdy) begin
            if (m_mode == 0 && hv && hr) begin
                if (ty == 2'd1) begin
                    e.sreq = 1; e.sidx = 32'(idx); nm = 1;
                end else begin
                    e.pop = 1;
                    if (ty != 2'd2) begin
                        e.en = 1; e.ridx = 32'(idx); e.rd = 32'(rd); e.val = val;
                    end
                    if (ty == 2'd3 || (ty == 2'd2 && pred != taken)) begin
                        nt = tgt; nm = 2;
                    end
                end
            end else if (m_mode == 1 && done) begin
                e.pop = 1; nm = 0;
            end else if (m_mode == 2) begin
                e.pj = 0; e.flush = 1; e.pc = m_tgt; nm = 0;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            m_commits = 0; m_redirects = 0;
        end else begin
            if (e.pop) m_commits++;
            if (nm == 2 && m_mode != 2) m_redirects++;
        end
        m_mode = nm; m_tgt = nt;
        cyc++;
        #1;
    endtask

    task automatic head(input logic v, input logic r, input logic [1:0] t, input logic [RW-1:0] i,
                        input logic [XW-1:0] d, input logic [31:0] x, input logic p, input logic k,
                        input logic [31:0] g);
        hv = v; hr = r; ty = t; idx = i; rd = d; val = x; pred = p; taken = k; tgt = g;
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pop",         e.cyc, 32'(pop),   32'(e.pop));
                chk("rf_en",       e.cyc, 32'(en),    32'(e.en));
                chk("rf_rd",       e.cyc, 32'(rrd),   e.rd);
                chk("rf_value",    e.cyc, rval,       e.val);
                chk("rf_index",    e.cyc, 32'(ridx),  e.ridx);
                chk("pre_judge",   e.cyc, 32'(pj),    32'(e.pj));
                chk("store_req",   e.cyc, 32'(sreq),  32'(e.sreq));
                chk("store_index", e.cyc, 32'(sidx),  e.sidx);
                chk("flush",       e.cyc, 32'(flush), 32'(e.flush));
                chk("flush_pc",    e.cyc, pc,         e.pc);
`ifdef COMMIT_PERF_CNT_EN
                chk("commit_cnt",  e.cyc, ccnt,       e.ccnt);
                chk("mispred_cnt", e.cyc, mcnt,       e.mcnt);
`endif
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        step();                          // reset state
        rst = 0;
        // Back-to-back register writes
        head(1, 1, 2'd0, 8'd7, 6'd5, 32'h1234, 0, 0, 0); step();
        head(1, 1, 2'd0, 8'd8, 6'd6, 32'h5678, 0, 0, 0); step();
        // Mispredicted branch, then a ready head that must not pop during the flush
        head(1, 1, 2'd2, 8'd9, 6'd0, 0, 1, 0, 32'h100); step();
        head(1, 1, 2'd0, 8'd10, 6'd2, 32'h22, 0, 0, 0); step();
        step();
        // Correctly predicted branch
        head(1, 1, 2'd2, 8'd11, 6'd0, 0, 1, 1, 32'h300); step();
        // Store with done arriving on the fourth wait cycle
        head(1, 1, 2'd1, 8'd3, 6'd0, 0, 0, 0, 0); step();
        head(0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        done = 1; step(); done = 0;
        // Jalr commits a register and redirects
        head(1, 1, 2'd3, 8'd12, 6'd1, 32'h44, 0, 0, 32'h200); step();
        head(0, 0, 2'd0, 0, 0, 0, 0, 0, 0); step();
        // Reset in the middle of a store wait; a later done is ignored
        head(1, 1, 2'd1, 8'd4, 6'd0, 0, 0, 0, 0); step();
        head(0, 0, 2'd0, 0, 0, 0, 0, 0, 0); step();
        rst = 1; step(); rst = 0;
        done = 1; step(); done = 0;
        // Freeze with a ready head, then release
        head(1, 1, 2'd0, 8'd20, 6'd3, 32'hABCD, 0, 0, 0);
        rdy = 0; repeat (3) step();
        rdy = 1; step();
        // Freeze during a redirect holds it
        head(1, 1, 2'd3, 8'd21, 6'd4, 32'h9, 0, 0, 32'h400); step();
        rdy = 0; step(); rdy = 1; step(); step();

        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 199) == 0);
            rdy  = ($urandom_range(0, 99) < 85);
            done = ($urandom_range(0, 3) == 0);
            head($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                 RW'($urandom), XW'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
            step();
        end
        rst = 0; rdy = 1; hv = 0; done = 0;
        @(negedge clk); @(negedge clk);
        chk("scoreboard_drained", cyc, 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_controller.md
COMMIT_CONTROLLER -- requirements
Module: commit_controller

Interface
REQ-001 SHALL have parameter RoB_WIDTH, default 8, RoB index width.
REQ-002 SHALL have parameter EX_REG_WIDTH, default 6, extended register index width; NON_REG = 6'b100000 means "no destination".
REQ-003 SHALL have ports as follows:
- Sys_clk  in  1  clock; all state updates on posedge.
- Sys_rst  in  1  asynchronous, active-high reset.
- Sys_rdy  in  1  high = advance; low = freeze.
- RoBCC_head_valid  in  1  RoB head entry exists.
- RoBCC_head_ready  in  1  head result available.
- RoBCC_head_type  in  2  0 = reg-write, 1 = store, 2 = branch, 3 = jalr.
- RoBCC_head_index  in  RoB_WIDTH  head RoB number.
- RoBCC_head_rd  in  EX_REG_WIDTH  head destination.
- RoBCC_head_value  in  32  head result.
- RoBCC_head_pred  in  1  predicted taken.
- RoBCC_head_taken  in  1  actual taken.
- RoBCC_head_target  in  32  correct next PC.
- CCRoB_pop  out  1  head retires at this posedge.
- CCRF_en  out  1  register-file commit valid.
- CCRF_RoB_index  out  RoB_WIDTH  commit RoB number.
- CCRF_rd  out  EX_REG_WIDTH  commit destination.
- CCRF_value  out  32  commit value.
- CCRF_pre_judge  out  1  0 = flush dependencies this cycle.
- CCLSB_store_req  out  1  store-commit request pulse.
- CCLSB_store_index  out  RoB_WIDTH  RoB number of the store.
- LSBCC_store_done  in  1  store written to memory.
- CCIF_flush  out  1  redirect fetch.
- CCIF_pc  out  32  redirect PC.

Function
REQ-004 SHALL implement FSM states RUN, STORE_WAIT, FLUSH; outputs combinational from state and head inputs.
REQ-005 Commit condition "go" SHALL be: state RUN, Sys_rdy high, head_valid high, head_ready high.
REQ-006 Type 0 on go: CCRoB_pop = 1, CCRF_en = 1, CCRF_rd/value/RoB_index = head fields; stay RUN.
REQ-007 Type 2 on go: CCRoB_pop = 1, CCRF_en = 0. If pred == taken, stay RUN. Otherwise latch head_target and go FLUSH.
REQ-008 Type 3 on go: pop plus register commit as type 0; latch head_target and go FLUSH unconditionally.
REQ-009 Type 1 on go: CCLSB_store_req = 1 for exactly that cycle, store_index = head_index, CCRoB_pop = 0; go STORE_WAIT.
REQ-010 In STORE_WAIT: LSBCC_store_done is sampled only in this state; on done with Sys_rdy high, CCRoB_pop = 1 and go RUN; otherwise hold with no req re-issue.
REQ-011 In FLUSH (one cycle, Sys_rdy high): CCRF_pre_judge = 0, CCIF_flush = 1, CCIF_pc = latched target, no pop and no commit regardless of head inputs; next state RUN.
REQ-012 Outside FLUSH, CCRF_pre_judge SHALL be 1 and CCIF_flush 0.
REQ-013 At most one pop per cycle; the cycle after a pop is eligible for a new commit (back-to-back throughput of 1/cycle for types 0 and 2).
REQ-014 Sys_rdy low SHALL force pop/en/store_req/flush to 0 and pre_judge to 1, and hold state and latched target.
REQ-015 When not committing, CCRF_rd SHALL be NON_REG and CCRF_value, CCRF_RoB_index and CCIF_pc 0 (except CCIF_pc in FLUSH).

Reset
REQ-016 Sys_rst high SHALL asynchronously force state RUN and latched target 0, even mid STORE_WAIT/FLUSH.
REQ-017 While Sys_rst is high, all enables SHALL be 0, pre_judge 1, CCRF_rd NON_REG, and all data outputs 0.

Configuration
REQ-018 With COMMIT_PERF_CNT_EN defined, SHALL add outputs CC_commit_cnt[31:0] (increments per pop) and CC_mispred_cnt[31:0] (increments per FLUSH entry), both reset to 0 and wrapping modulo 2^32.
REQ-019 Without COMMIT_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-020 Type 0 head, rd = 5, value = 0x1234, index = 7, ready -> same cycle pop = 1, CCRF_en = 1, rd = 5, value = 0x1234; next head commits the next cycle.
REQ-021 Branch pred = 1, taken = 0, target = 0x100 -> pop that cycle; next cycle pre_judge = 0, flush = 1, CCIF_pc = 0x100; a ready head during FLUSH is not popped.
REQ-022 Store index = 3 -> store_req 1-cycle pulse with index 3; done after 4 cycles -> pop exactly on the done cycle, none earlier.
REQ-023 Jalr rd = 1, value = 0x44, target = 0x200 -> commit rd = 1 with pre_judge = 1, then FLUSH cycle to 0x200.
REQ-024 Sys_rst asserted mid STORE_WAIT -> immediate RUN, outputs at reset values; done later ignored.
REQ-025 Sys_rdy low during ready head -> no pop or commit until Sys_rdy returns high; with COMMIT_PERF_CNT_EN, counters match pops and flushes.
